// File: rtl/cfi_shadow_stack_backend.sv
// CFI shadow-stack backend: drains the CFI log queue, mirrors call/return pairs
// on a circular shadow stack and raises a one-cycle fault on mismatch/underflow.
// Optional build macro CFI_SS_OVERFLOW_TRAP_EN: a call on a full stack traps
// instead of overwriting the oldest entry.

package riscv;
    localparam int unsigned VLEN = 64;
    localparam int unsigned XLEN = 64;
endpackage

package cfi_ss_pkg;
    typedef enum logic [1:0] {
        CFI_BRANCH = 2'd0,
        CFI_JUMP   = 2'd1,
        CFI_CALL   = 2'd2,
        CFI_RETURN = 2'd3
    } cfi_kind_e;

    typedef struct packed {
        cfi_kind_e              kind;
        logic [riscv::VLEN-1:0] pc;
        logic [riscv::VLEN-1:0] target;
        logic                   is_rvc;
    } cfi_log_t;

    typedef struct packed {
        logic [riscv::XLEN-1:0] cause;
        logic [riscv::XLEN-1:0] tval;
        logic                   valid;
    } exception_t;
endpackage

module cfi_shadow_stack_backend
    import cfi_ss_pkg::*;
#(
    parameter int unsigned SS_DEPTH    = 16,
    parameter logic [63:0] FAULT_CAUSE = 64'd24
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  cfi_log_t                     log_i,
    input  logic                         queue_empty_i,
    output logic                         queue_pop_o,
    output exception_t                   cfi_fault_o,
    output logic [$clog2(SS_DEPTH):0]    ss_usage_o
);

    localparam int unsigned PTR_W = $clog2(SS_DEPTH);
    localparam int unsigned USE_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, CHECK, FAULT} state_e;

    state_e                 state_q, state_d;
    cfi_log_t               log_q;
    logic [PTR_W-1:0]       sp_q;
    logic [USE_W-1:0]       usage_q;
    logic [riscv::VLEN-1:0] tval_q, tval_d;
    logic                   rdy_q;
    logic [riscv::VLEN-1:0] stack_q [SS_DEPTH];

    logic                   push, pop, full;
    logic [PTR_W-1:0]       sp_m1;
    logic [riscv::VLEN-1:0] ret_addr, top;

    assign full     = (usage_q == USE_W'(SS_DEPTH));
    assign sp_m1    = sp_q - PTR_W'(1);
    assign top      = stack_q[sp_m1];
    assign ret_addr = log_q.pc + (log_q.is_rvc ? riscv::VLEN'(2) : riscv::VLEN'(4));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        tval_d      = tval_q;
        queue_pop_o = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                // rdy_q keeps the pop quiet in the first cycle out of reset
                if (rst_ni && rdy_q && !queue_empty_i) begin
                    queue_pop_o = 1'b1;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
                case (log_q.kind)
                    CFI_CALL: begin
`ifdef CFI_SS_OVERFLOW_TRAP_EN
                        if (full) begin
                            state_d = FAULT;
                            tval_d  = log_q.pc;
                        end else begin
                            push = 1'b1;
                        end
`else
                        push = 1'b1;
`endif
                    end
                    CFI_RETURN: begin
                        if (usage_q != '0) begin
                            pop = 1'b1;
                            if (log_q.target != top) begin
                                state_d = FAULT;
                                tval_d  = log_q.target;
                            end
                        end else begin
                            state_d = FAULT;
                            tval_d  = log_q.target;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdy_q   <= 1'b0;
            log_q   <= '0;
            sp_q    <= '0;
            usage_q <= '0;
            tval_q  <= '0;
        end else begin
            rdy_q  <= 1'b1;
            tval_q <= tval_d;
            if (queue_pop_o) log_q <= log_i;
            if (push) begin
                // a push on a full stack overwrites the oldest slot
                sp_q <= sp_q + PTR_W'(1);
                if (!full) usage_q <= usage_q + USE_W'(1);
            end else if (pop) begin
                sp_q    <= sp_m1;
                usage_q <= usage_q - USE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push) stack_q[sp_q] <= ret_addr;
    end

    always_comb begin
        cfi_fault_o = '0;
        if (rst_ni && state_q == FAULT) begin
            cfi_fault_o.valid = 1'b1;
            cfi_fault_o.cause = FAULT_CAUSE;
            cfi_fault_o.tval  = tval_q;
        end
    end

    assign ss_usage_o = rst_ni ? usage_q : '0;

endmodule

// File: tb/tb_cfi_shadow_stack_backend.sv
// Scoreboard bench for cfi_shadow_stack_backend: a queue-based stack model
// predicts fault/usage per log entry; monitors count pops and fault pulses.
module tb_cfi_shadow_stack_backend;
    import cfi_ss_pkg::*;

    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic        flt;
        logic [63:0] tval;
        int          usage;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    cfi_log_t    log_i;
    logic        queue_empty_i;
    logic        queue_pop_o;
    exception_t  cfi_fault_o;
    logic [$clog2(DEPTH):0] ss_usage_o;

    int n_tests = 0;
    int n_fail  = 0;
    int pop_cnt = 0, pop_exp = 0;
    int flt_cnt = 0, flt_exp = 0;

    exp_t        exp_q[$];
    logic [63:0] mstk[$];

    cfi_shadow_stack_backend #(.SS_DEPTH(DEPTH), .FAULT_CAUSE(64'd24)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .log_i         (log_i),
        .queue_empty_i (queue_empty_i),
        .queue_pop_o   (queue_pop_o),
        .cfi_fault_o   (cfi_fault_o),
        .ss_usage_o    (ss_usage_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (queue_pop_o) pop_cnt++;
        if (cfi_fault_o.valid) flt_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ret_of(input logic [63:0] pc, input logic rvc);
        return pc + (rvc ? 64'd2 : 64'd4);
    endfunction

    // Reference model: the queue back is the stack top, front is the oldest entry.
    function automatic exp_t model(input cfi_kind_e k, input logic [63:0] pc,
                                   input logic [63:0] tgt, input logic rvc);
        exp_t e;
        logic [63:0] v;
        e.flt = 1'b0;
        e.tval = '0;
        if (k == CFI_CALL) begin
            if (mstk.size() == DEPTH) begin
`ifdef CFI_SS_OVERFLOW_TRAP_EN
                e.flt = 1'b1;
                e.tval = pc;
`else
                void'(mstk.pop_front());
                mstk.push_back(ret_of(pc, rvc));
`endif
            end else begin
                mstk.push_back(ret_of(pc, rvc));
            end
        end else if (k == CFI_RETURN) begin
            if (mstk.size() == 0) begin
                e.flt = 1'b1;
                e.tval = tgt;
            end else begin
                v = mstk.pop_back();
                if (v != tgt) begin
                    e.flt = 1'b1;
                    e.tval = tgt;
                end
            end
        end
        e.usage = mstk.size();
        return e;
    endfunction

    // Called #1 after a posedge with the DUT in IDLE; returns likewise.
    task automatic send(input cfi_kind_e k, input logic [63:0] pc,
                        input logic [63:0] tgt, input logic rvc);
        exp_t e;
        int n;
        exp_q.push_back(model(k, pc, tgt, rvc));
        if (exp_q[$].flt) flt_exp++;
        pop_exp++;
        log_i = '{kind: k, pc: pc, target: tgt, is_rvc: rvc};
        queue_empty_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (!queue_pop_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!queue_pop_o) begin
            chk("pop_timeout", 64'd0, 64'd1);
            queue_empty_i = 1'b1;
            void'(exp_q.pop_front());
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        queue_empty_i = 1'b1;
        log_i = '0;
        @(negedge clk);
        chk("pop_once", {63'd0, queue_pop_o}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("flt_vld", {63'd0, cfi_fault_o.valid}, {63'd0, e.flt});
        if (e.flt) begin
            chk("flt_cause", cfi_fault_o.cause, 64'd24);
            chk("flt_tval", cfi_fault_o.tval, e.tval);
        end
        chk("usage", 64'(ss_usage_o), 64'(e.usage));
        if (e.flt) begin
            @(negedge clk);
            chk("flt_pulse", {63'd0, cfi_fault_o.valid}, 64'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] pcs [17];
        rst_n = 1'b0;
        queue_empty_i = 1'b0;
        log_i = '{kind: CFI_CALL, pc: 64'h1000, target: 64'h0, is_rvc: 1'b0};

        // reset with a non-empty queue: nothing may be popped or reported
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pop", {63'd0, queue_pop_o}, 64'd0);
        chk("rst_flt", cfi_fault_o, '0);
        chk("rst_usage", 64'(ss_usage_o), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_pop", {63'd0, queue_pop_o}, 64'd0);
        chk("post_rst_flt", {63'd0, cfi_fault_o.valid}, 64'd0);
        queue_empty_i = 1'b1;
        log_i = '0;
        @(posedge clk); #1;

        // matched call/return
        send(CFI_CALL,   64'h8000_2000, 64'h0,          1'b0);
        send(CFI_RETURN, 64'h8000_2100, 64'h8000_2004, 1'b0);
        // rvc call returns to pc+2, so pc+4 is a mismatch
        send(CFI_CALL,   64'h8000_3000, 64'h0,          1'b1);
        send(CFI_RETURN, 64'h8000_3100, 64'h8000_3004, 1'b0);
        // underflow
        send(CFI_RETURN, 64'h8000_4100, 64'h8000_4000, 1'b0);

        // idle queue then a branch; stack must be untouched
        send(CFI_CALL, 64'h8000_7000, 64'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_pop", {63'd0, queue_pop_o}, 64'd0);
        end
        @(posedge clk); #1;
        send(CFI_BRANCH, 64'h8000_7100, 64'h8000_7200, 1'b0);
        send(CFI_JUMP,   64'h8000_7200, 64'h8000_7300, 1'b1);
        send(CFI_RETURN, 64'h8000_7400, 64'h8000_7002, 1'b0);

        // 17 calls at depth 16, then unwind
        for (int i = 0; i < 17; i++) begin
            pcs[i] = 64'h8000_5000 + 64'(i) * 64'h10;
            send(CFI_CALL, pcs[i], 64'h0, i[0]);
        end
`ifdef CFI_SS_OVERFLOW_TRAP_EN
        for (int i = 15; i >= 0; i--)
            send(CFI_RETURN, 64'h9000_0000, ret_of(pcs[i], i[0]), 1'b0);
`else
        for (int i = 16; i >= 1; i--)
            send(CFI_RETURN, 64'h9000_0000, ret_of(pcs[i], i[0]), 1'b0);
        // first call's address was overwritten, so this is an underflow
        send(CFI_RETURN, 64'h9000_0000, ret_of(pcs[0], 1'b0), 1'b0);
`endif

        // reset during CHECK of a mismatching return aborts it
        send(CFI_CALL, 64'h8000_6000, 64'h0, 1'b0);
        log_i = '{kind: CFI_RETURN, pc: 64'h8000_6100, target: 64'h8000_6abc, is_rvc: 1'b0};
        queue_empty_i = 1'b0;
        @(negedge clk);
        chk("abort_pop", {63'd0, queue_pop_o}, 64'd1);
        pop_exp++;
        @(posedge clk); #1;
        queue_empty_i = 1'b1;
        log_i = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_flt0", {63'd0, cfi_fault_o.valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_flt1", {63'd0, cfi_fault_o.valid}, 64'd0);
        chk("abort_usage", 64'(ss_usage_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mstk.delete();
        @(negedge clk);
        chk("abort_post_flt", {63'd0, cfi_fault_o.valid}, 64'd0);
        chk("abort_post_usage", 64'(ss_usage_o), 64'd0);
        @(posedge clk); #1;
        send(CFI_BRANCH, 64'h8000_8000, 64'h8000_8100, 1'b0);
        send(CFI_RETURN, 64'h8000_8200, 64'h8000_6004, 1'b0);

        repeat (2) @(posedge clk);
        chk("pop_count", 64'(pop_cnt), 64'(pop_exp));
        chk("flt_count", 64'(flt_cnt), 64'(flt_exp));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
